// File: rtl/wheel_pwm_driver.sv
// Two-wheel PWM motor driver: slew-limited duty, brake, and direction-safe reversal.
// Optional feature macro WHEEL_DEADTIME_EN adds a DEAD_CYCLES dead time before each direction flip.

module wheel_pwm_channel #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_FWD    = 200,
    parameter int DUTY_REV    = 128,
    parameter int RAMP_STEP   = 8
`ifdef WHEEL_DEADTIME_EN
    ,
    parameter int DEAD_CYCLES = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                en,
    input  logic [1:0]          cmd,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                pwm,
    output logic                dir,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam logic [2:0] ST_STOP  = 3'd0;
    localparam logic [2:0] ST_RAMP  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_BRAKE = 3'd3;
    localparam logic [2:0] ST_DEAD  = 3'd4;

    localparam logic [PWM_BITS-1:0] ZERO_W = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] FWD_W  = PWM_BITS'(DUTY_FWD);
    localparam logic [PWM_BITS-1:0] REV_W  = PWM_BITS'(DUTY_REV);
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(RAMP_STEP);

    logic [2:0]          state_r, state_s;
    logic [PWM_BITS-1:0] duty_r, duty_s;
    logic [PWM_BITS-1:0] base_tgt_s, eff_tgt_s;
    logic                dir_r, dir_s, pwm_r;
    logic                brake_s, drive_s, req_dir_s, reversal_s;

`ifdef WHEEL_DEADTIME_EN
    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);
    logic [15:0] dead_cnt_r, dead_cnt_s;
`endif

    function automatic logic [PWM_BITS-1:0] ramp_toward(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        logic [PWM_BITS:0]   cur_w;
        logic [PWM_BITS:0]   tgt_w;
        logic [PWM_BITS:0]   mov_w;
        logic [PWM_BITS-1:0] res;
        cur_w = {1'b0, cur};
        tgt_w = {1'b0, tgt};
        mov_w = {(PWM_BITS+1){1'b0}};
        if (cur_w < tgt_w) begin
            mov_w = cur_w + STEP_W;
            res   = (mov_w > tgt_w) ? tgt : mov_w[PWM_BITS-1:0];
        end else if (cur_w > tgt_w) begin
            // anything closer than one step clamps to the target instead of undershooting
            mov_w = tgt_w + STEP_W;
            if (cur_w < mov_w) begin
                res = tgt;
            end else begin
                mov_w = cur_w - STEP_W;
                res   = mov_w[PWM_BITS-1:0];
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Decode the registered command into a target duty and requested direction.
    always_comb begin
        brake_s   = (cmd == 2'b11);
        req_dir_s = (cmd == 2'b10);
        case (cmd)
            2'b01:   base_tgt_s = FWD_W;
            2'b10:   base_tgt_s = REV_W;
            default: base_tgt_s = ZERO_W;
        endcase
        if (!en) begin
            base_tgt_s = ZERO_W;
        end else begin
            base_tgt_s = base_tgt_s;
        end
        drive_s    = (base_tgt_s != ZERO_W);
        reversal_s = drive_s && (req_dir_s != dir_r);
        eff_tgt_s  = reversal_s ? ZERO_W : base_tgt_s;
        busy       = ((state_r != ST_STOP) && (state_r != ST_HOLD)) || (eff_tgt_s != duty_r);
    end

    // Channel state machine: next state, duty and direction.
    always_comb begin
        state_s = state_r;
        duty_s  = duty_r;
        dir_s   = dir_r;
`ifdef WHEEL_DEADTIME_EN
        dead_cnt_s = dead_cnt_r;
`endif
        if (brake_s) begin
            state_s = ST_BRAKE;
            duty_s  = ZERO_W;
        end else begin
            case (state_r)
                ST_STOP: begin
                    duty_s = ZERO_W;
                    if (drive_s) begin
                        dir_s   = req_dir_s;
                        state_s = ST_RAMP;
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                ST_RAMP: begin
                    duty_s = tick ? ramp_toward(duty_r, eff_tgt_s) : duty_r;
                    if (duty_s != eff_tgt_s) begin
                        state_s = ST_RAMP;
                    end else if (eff_tgt_s != ZERO_W) begin
                        state_s = ST_HOLD;
`ifdef WHEEL_DEADTIME_EN
                    end else if (reversal_s) begin
                        state_s    = ST_DEAD;
                        dead_cnt_s = 16'd0;
`endif
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                ST_HOLD: begin
                    state_s = (eff_tgt_s != duty_r) ? ST_RAMP : ST_HOLD;
                end
                ST_BRAKE: begin
                    duty_s  = ZERO_W;
                    state_s = ST_STOP;
                end
`ifdef WHEEL_DEADTIME_EN
                ST_DEAD: begin
                    duty_s = ZERO_W;
                    if (drive_s && !reversal_s) begin
                        state_s = ST_STOP;
                    end else if (dead_cnt_r == DEAD_LAST) begin
                        dir_s   = ~dir_r;
                        state_s = ST_STOP;
                    end else begin
                        dead_cnt_s = dead_cnt_r + 16'd1;
                    end
                end
`endif
                default: begin
                    state_s = ST_STOP;
                    duty_s  = ZERO_W;
                end
            endcase
        end
    end

    // Channel registers; the PWM compare uses the duty being loaded this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_STOP;
            duty_r  <= ZERO_W;
            dir_r   <= 1'b0;
            pwm_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            duty_r  <= duty_s;
            dir_r   <= dir_s;
            pwm_r   <= (cnt < duty_s);
        end
    end

`ifdef WHEEL_DEADTIME_EN
    // Dead-time counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            dead_cnt_r <= 16'd0;
        end else begin
            dead_cnt_r <= dead_cnt_s;
        end
    end
`endif

    assign pwm  = pwm_r;
    assign dir  = dir_r;
    assign duty = duty_r;

endmodule

module wheel_pwm_driver #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_FWD    = 200,
    parameter int DUTY_REV    = 128,
    parameter int RAMP_STEP   = 8,
    parameter int RAMP_DIV    = 256,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          rWheel,
    input  logic [1:0]          lWheel,
    output logic                r_pwm,
    output logic                r_dir,
    output logic                l_pwm,
    output logic                l_dir,
    output logic [PWM_BITS-1:0] r_duty,
    output logic [PWM_BITS-1:0] l_duty,
    output logic                busy
);

    localparam logic [15:0] DIV_LAST = 16'(RAMP_DIV - 1);

    if ((RAMP_DIV < 2) || (RAMP_DIV > 65535) || (RAMP_STEP < 1) || (DEAD_CYCLES < 1)) begin : g_bad_cfg
        $error("wheel_pwm_driver: illegal parameter set");
    end

    logic [PWM_BITS-1:0] cnt_r;
    logic [15:0]         pre_r;
    logic                tick_s;
    logic [1:0]          r_cmd_r, l_cmd_r;
    logic                en_r, busy_r;
    logic                r_busy_s, l_busy_s;

    assign tick_s = (pre_r == DIV_LAST);

    // Shared PWM counter, ramp prescaler, command capture and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {PWM_BITS{1'b0}};
            pre_r   <= 16'd0;
            r_cmd_r <= 2'b00;
            l_cmd_r <= 2'b00;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            cnt_r   <= cnt_r + PWM_BITS'(1);
            pre_r   <= tick_s ? 16'd0 : pre_r + 16'd1;
            r_cmd_r <= rWheel;
            l_cmd_r <= lWheel;
            en_r    <= enable;
            busy_r  <= r_busy_s | l_busy_s;
        end
    end

    wheel_pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .DUTY_FWD   (DUTY_FWD),
        .DUTY_REV   (DUTY_REV),
        .RAMP_STEP  (RAMP_STEP)
`ifdef WHEEL_DEADTIME_EN
        ,
        .DEAD_CYCLES(DEAD_CYCLES)
`endif
    ) u_right (
        .clk  (clk),
        .reset(reset),
        .tick (tick_s),
        .en   (en_r),
        .cmd  (r_cmd_r),
        .cnt  (cnt_r),
        .pwm  (r_pwm),
        .dir  (r_dir),
        .duty (r_duty),
        .busy (r_busy_s)
    );

    wheel_pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .DUTY_FWD   (DUTY_FWD),
        .DUTY_REV   (DUTY_REV),
        .RAMP_STEP  (RAMP_STEP)
`ifdef WHEEL_DEADTIME_EN
        ,
        .DEAD_CYCLES(DEAD_CYCLES)
`endif
    ) u_left (
        .clk  (clk),
        .reset(reset),
        .tick (tick_s),
        .en   (en_r),
        .cmd  (l_cmd_r),
        .cnt  (cnt_r),
        .pwm  (l_pwm),
        .dir  (l_dir),
        .duty (l_duty),
        .busy (l_busy_s)
    );

    assign busy = busy_r;

endmodule

// File: tb/tb_wheel_pwm_driver.sv
// Directed self-checking bench for wheel_pwm_driver (RAMP_DIV=4) plus a RAMP_STEP=60 instance.
module tb_wheel_pwm_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable;
    logic [1:0] rWheel, lWheel;
    logic       r_pwm, r_dir, l_pwm, l_dir, busy;
    logic [7:0] r_duty, l_duty;

    logic       reset2, enable2;
    logic [1:0] rWheel2, lWheel2;
    logic       r_pwm2, r_dir2, l_pwm2, l_dir2, busy2;
    logic [7:0] r_duty2, l_duty2;

    int checks = 0;
    int errors = 0;

`ifdef WHEEL_DEADTIME_EN
    localparam int FLIP_DELAY = 16;
`else
    localparam int FLIP_DELAY = 1;
`endif

    wheel_pwm_driver #(.PWM_BITS(8), .DUTY_FWD(200), .DUTY_REV(128), .RAMP_STEP(8),
                       .RAMP_DIV(4), .DEAD_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rWheel(rWheel), .lWheel(lWheel),
        .r_pwm(r_pwm), .r_dir(r_dir), .l_pwm(l_pwm), .l_dir(l_dir),
        .r_duty(r_duty), .l_duty(l_duty), .busy(busy));

    wheel_pwm_driver #(.PWM_BITS(8), .DUTY_FWD(200), .DUTY_REV(128), .RAMP_STEP(60),
                       .RAMP_DIV(4), .DEAD_CYCLES(16)) dut2 (
        .clk(clk), .reset(reset2), .enable(enable2), .rWheel(rWheel2), .lWheel(lWheel2),
        .r_pwm(r_pwm2), .r_dir(r_dir2), .l_pwm(l_pwm2), .l_dir(l_dir2),
        .r_duty(r_duty2), .l_duty(l_duty2), .busy(busy2));

    task step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function logic [7:0] duty_of(input int sel);
        case (sel)
            0:       return r_duty;
            1:       return l_duty;
            default: return r_duty2;
        endcase
    endfunction

    task wait_change(input int sel, input logic [7:0] prev, input int limit, output int cycles);
        int n;
        n = 0;
        cycles = -1;
        while (n < limit && cycles < 0) begin
            step(1);
            n++;
            if (duty_of(sel) !== prev) cycles = n;
        end
    endtask

    task wait_value(input int sel, input logic [7:0] val, input int limit, output int cycles);
        int n;
        n = 0;
        cycles = -1;
        while (n < limit && cycles < 0) begin
            step(1);
            n++;
            if (duty_of(sel) === val) cycles = n;
        end
    endtask

    task do_reset();
        reset = 1'b1; rWheel = 2'b00; lWheel = 2'b00; enable = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task test_reset();
        reset = 1'b1; enable = 1'b1; rWheel = 2'b00; lWheel = 2'b00;
        step(2);
        checks++;
        if ({r_pwm, r_dir, l_pwm, l_dir, r_duty, l_duty, busy} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {r_pwm, r_dir, l_pwm, l_dir, r_duty, l_duty, busy});
        end
        reset = 1'b0;
        step(4);
        checks++;
        if ({r_duty, l_duty, busy, r_pwm, l_pwm} !== 19'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0", {r_duty, l_duty, busy, r_pwm, l_pwm});
        end
    endtask

    task test_forward_ramp();
        logic [7:0] prev;
        int cyc, hi_r, hi_l;
        rWheel = 2'b01;
        prev = 8'd0;
        for (int k = 1; k <= 25; k++) begin
            wait_change(0, prev, 8, cyc);
            checks++;
            if (r_duty !== 8'(8 * k)) begin
                errors++;
                $display("FAIL fwd_step%0d: got %0d expected %0d", k, r_duty, 8 * k);
            end
            if (k > 1) begin
                checks++;
                if (cyc !== 4) begin
                    errors++;
                    $display("FAIL fwd_interval%0d: got %0d cycles expected 4", k, cyc);
                end
            end
            if (k == 10) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid_ramp: got %b expected 1", busy);
                end
            end
            prev = r_duty;
        end
        step(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_hold: got %b expected 0", busy);
        end
        hi_r = 0;
        hi_l = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (r_pwm === 1'b1) hi_r++;
            if (l_pwm !== 1'b0) hi_l++;
        end
        checks++;
        if (hi_r !== 200) begin
            errors++;
            $display("FAIL r_pwm_high_count: got %0d expected 200", hi_r);
        end
        checks++;
        if (hi_l !== 0 || l_duty !== 8'd0) begin
            errors++;
            $display("FAIL l_idle: got high=%0d duty=%0d expected 0/0", hi_l, l_duty);
        end
        checks++;
        if (r_duty !== 8'd200 || r_dir !== 1'b0) begin
            errors++;
            $display("FAIL fwd_hold: got duty=%0d dir=%b expected 200/0", r_duty, r_dir);
        end
    endtask

    task test_reversal();
        logic [7:0] prev;
        int cyc, n;
        rWheel = 2'b10;
        prev = r_duty;
        for (int k = 1; k <= 25; k++) begin
            wait_change(0, prev, 8, cyc);
            checks++;
            if (r_duty !== 8'(200 - 8 * k) || r_dir !== 1'b0) begin
                errors++;
                $display("FAIL rev_down%0d: got duty=%0d dir=%b expected %0d/0", k, r_duty, r_dir, 200 - 8 * k);
            end
            prev = r_duty;
        end
        n = 0;
        while (n < 40 && r_dir !== 1'b1) begin
            step(1);
            n++;
        end
        checks++;
        if (n !== FLIP_DELAY || r_duty !== 8'd0) begin
            errors++;
            $display("FAIL dir_flip: got %0d cycles duty=%0d expected %0d/0", n, r_duty, FLIP_DELAY);
        end
        prev = 8'd0;
        for (int k = 1; k <= 16; k++) begin
            wait_change(0, prev, 8, cyc);
            checks++;
            if (r_duty !== 8'(8 * k) || r_dir !== 1'b1) begin
                errors++;
                $display("FAIL rev_up%0d: got duty=%0d dir=%b expected %0d/1", k, r_duty, r_dir, 8 * k);
            end
            prev = r_duty;
        end
        step(8);
        checks++;
        if (r_duty !== 8'd128 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rev_hold: got duty=%0d busy=%b expected 128/0", r_duty, busy);
        end
    endtask

    task test_brake();
        int cyc, hi;
        do_reset();
        rWheel = 2'b01;
        wait_value(0, 8'd104, 150, cyc);
        checks++;
        if (r_duty !== 8'd104) begin
            errors++;
            $display("FAIL brake_setup: got %0d expected 104", r_duty);
        end
        rWheel = 2'b11;
        step(2);
        checks++;
        if (r_duty !== 8'd0 || r_pwm !== 1'b0 || r_dir !== 1'b0) begin
            errors++;
            $display("FAIL brake_2cyc: got duty=%0d pwm=%b dir=%b expected 0/0/0", r_duty, r_pwm, r_dir);
        end
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (r_pwm !== 1'b0 || r_duty !== 8'd0) hi++;
        end
        checks++;
        if (hi !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL brake_hold: got active=%0d busy=%b expected 0/1", hi, busy);
        end
        rWheel = 2'b00;
        step(4);
        checks++;
        if (r_duty !== 8'd0 || busy !== 1'b0 || r_dir !== 1'b0) begin
            errors++;
            $display("FAIL brake_release: got duty=%0d busy=%b dir=%b expected 0/0/0", r_duty, busy, r_dir);
        end
    endtask

    task test_enable();
        int cyc, skew;
        rWheel = 2'b01;
        lWheel = 2'b01;
        wait_value(0, 8'd200, 300, cyc);
        checks++;
        if (r_duty !== 8'd200 || l_duty !== 8'd200) begin
            errors++;
            $display("FAIL en_both_up: got r=%0d l=%0d expected 200/200", r_duty, l_duty);
        end
        enable = 1'b0;
        wait_change(0, 8'd200, 10, cyc);
        checks++;
        if (r_duty !== 8'd192) begin
            errors++;
            $display("FAIL en_first_down: got %0d expected 192", r_duty);
        end
        skew = 0;
        for (int i = 0; i < 150; i++) begin
            step(1);
            if (r_duty !== l_duty) skew++;
        end
        checks++;
        if (skew !== 0 || r_duty !== 8'd0 || l_duty !== 8'd0 || r_dir !== 1'b0 || l_dir !== 1'b0) begin
            errors++;
            $display("FAIL en_both_down: got skew=%0d r=%0d l=%0d expected 0/0/0", skew, r_duty, l_duty);
        end
        enable = 1'b1;
        wait_value(1, 8'd200, 300, cyc);
        checks++;
        if (r_duty !== 8'd200 || l_duty !== 8'd200) begin
            errors++;
            $display("FAIL en_back_up: got r=%0d l=%0d expected 200/200", r_duty, l_duty);
        end
    endtask

    task test_reset_midramp();
        int cyc;
        do_reset();
        rWheel = 2'b01;
        wait_value(0, 8'd64, 100, cyc);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({r_pwm, r_dir, l_pwm, l_dir, r_duty, l_duty, busy} !== 21'd0) begin
            errors++;
            $display("FAIL midramp_reset: got %h expected 0", {r_pwm, r_dir, l_pwm, l_dir, r_duty, l_duty, busy});
        end
        step(3);
        checks++;
        if (r_duty !== 8'd0) begin
            errors++;
            $display("FAIL restart_wait: got %0d expected 0", r_duty);
        end
        step(1);
        checks++;
        if (r_duty !== 8'd8) begin
            errors++;
            $display("FAIL restart_first_tick: got %0d expected 8", r_duty);
        end
    endtask

    task test_big_step();
        logic [7:0] exp_seq [11];
        logic [7:0] prev;
        int cyc, n, hi;
        exp_seq = '{8'd60, 8'd120, 8'd180, 8'd200, 8'd140, 8'd80, 8'd20, 8'd0, 8'd60, 8'd120, 8'd128};
        reset2 = 1'b1; enable2 = 1'b1; rWheel2 = 2'b00; lWheel2 = 2'b00;
        step(2);
        reset2 = 1'b0;
        rWheel2 = 2'b01;
        prev = 8'd0;
        for (int k = 0; k < 11; k++) begin
            if (k == 4) rWheel2 = 2'b10;
            if (k == 8) begin
                n = 0;
                while (n < 40 && r_dir2 !== 1'b1) begin
                    step(1);
                    n++;
                end
                checks++;
                if (n !== FLIP_DELAY) begin
                    errors++;
                    $display("FAIL big_dir_flip: got %0d cycles expected %0d", n, FLIP_DELAY);
                end
            end
            wait_change(2, prev, 40, cyc);
            checks++;
            if (r_duty2 !== exp_seq[k]) begin
                errors++;
                $display("FAIL big_step%0d: got %0d expected %0d", k, r_duty2, exp_seq[k]);
            end
            prev = r_duty2;
        end
        step(4);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (r_pwm2 === 1'b1) hi++;
        end
        checks++;
        if (hi !== 128 || r_duty2 !== 8'd128 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL big_hold: got high=%0d duty=%0d busy=%b expected 128/128/0", hi, r_duty2, busy2);
        end
        checks++;
        if ({l_pwm2, l_dir2, l_duty2} !== 10'd0) begin
            errors++;
            $display("FAIL big_left_idle: got %h expected 0", {l_pwm2, l_dir2, l_duty2});
        end
    endtask

    initial begin
        reset2 = 1'b1; enable2 = 1'b1; rWheel2 = 2'b00; lWheel2 = 2'b00;
        test_reset();
        test_forward_ramp();
        test_reversal();
        test_brake();
        test_enable();
        test_reset_midramp();
        test_big_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
